bus_ram_slave: RTL and testbench

- Word-addressed on-chip RAM target on the shared OR'd system bus; sits directly downstream of the CPU bus master, alongside the SPART.
- Decodes an address window and services single and burst reads/writes with per-byte write enables.
- Drives all bus outputs to zero when not addressed, so its outputs OR cleanly with the other slaves.

---
 rtl/bus_ram_slave.sv | 176 +++++++++++++++++
 tb/tb_bus_ram_slave.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_ram_slave.sv
// Word-addressed RAM target on the OR'd system bus: single/burst reads and writes with byte lanes.
// Build option BUS_RAM_WRAP_BURST_EN: bursts wrap modulo SIZE_WORDS instead of terminating with an error.
module bus_ram_slave #(
   parameter logic [31:0] BASE_ADDR  = 32'h0001_0000,
   parameter int          SIZE_WORDS = 1024,
   parameter int          READ_WAIT  = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] bus_addrData_i,
   input  logic [3:0]  bus_byteEnables_i,
   input  logic [7:0]  bus_burstSize_i,
   input  logic        bus_readNWrite_i,
   input  logic        bus_beginTransaction_i,
   input  logic        bus_endTransaction_i,
   input  logic        bus_dataValid_i,
   output logic [31:0] bus_addrData_o,
   output logic        bus_endTransaction_o,
   output logic        bus_dataValid_o,
   output logic        bus_busy_o,
   output logic        bus_error_o
);

   localparam int IDX_W   = $clog2(SIZE_WORDS);
   localparam int TAG_LSB = IDX_W + 2;
   localparam logic [3:0] WAIT_LOAD = 4'((READ_WAIT > 0) ? (READ_WAIT - 1) : 0);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_DATA = 3'd1,
      RD_WAIT = 3'd2,
      RD_DATA = 3'd3,
      ERR     = 3'd4
   } state_t;

   state_t           state_r, nxtState_s;
   logic [IDX_W-1:0] idx_r, nxtIdx_s, reqIdx_s;
   logic [3:0]       be_r, nxtBe_s;
   logic [7:0]       remain_r, nxtRemain_s, beats_s;
   logic [3:0]       waitCnt_r, nxtWaitCnt_s;
   logic             hit_s, winErr_s, wrBeat_s, rdBeat_s;
   logic             nxtValid_s, nxtEnd_s, nxtErr_s, nxtBusy_s;
   logic             unusedAddrBits_s;
   logic [31:0]      mem_r [0:SIZE_WORDS-1];

   // Base alignment lets the hit test reduce to an upper-bit tag compare.
   assign hit_s            = (bus_addrData_i[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]);
   assign reqIdx_s         = bus_addrData_i[TAG_LSB-1:2];
   assign beats_s          = (bus_burstSize_i == 8'd0) ? 8'd1 : bus_burstSize_i;
   assign unusedAddrBits_s = ^bus_addrData_i[1:0];

`ifdef BUS_RAM_WRAP_BURST_EN
   assign winErr_s = 1'b0;
`else
   logic [IDX_W+8:0] reqEnd_s;
   assign reqEnd_s = (IDX_W+9)'(reqIdx_s) + (IDX_W+9)'(beats_s);
   assign winErr_s = (reqEnd_s > (IDX_W+9)'(SIZE_WORDS));
`endif

   // Next-state, capture values and next registered bus outputs
   always_comb begin
      nxtState_s   = state_r;
      nxtIdx_s     = idx_r;
      nxtBe_s      = be_r;
      nxtRemain_s  = remain_r;
      nxtWaitCnt_s = waitCnt_r;
      wrBeat_s     = 1'b0;
      rdBeat_s     = 1'b0;
      nxtValid_s   = 1'b0;
      nxtEnd_s     = 1'b0;
      nxtErr_s     = 1'b0;
      case (state_r)
         IDLE: begin
            if (bus_beginTransaction_i && hit_s) begin
               nxtIdx_s     = reqIdx_s;
               nxtBe_s      = bus_byteEnables_i;
               nxtRemain_s  = beats_s;
               nxtWaitCnt_s = WAIT_LOAD;
               if (winErr_s) begin
                  nxtState_s = ERR;
               end else if (!bus_readNWrite_i) begin
                  nxtState_s = WR_DATA;
               end else if (READ_WAIT == 0) begin
                  nxtState_s = RD_DATA;
               end else begin
                  nxtState_s = RD_WAIT;
               end
            end else begin
               nxtState_s = IDLE;
            end
         end
         WR_DATA: begin
            // Beats beyond the captured count are accepted on the bus but not stored.
            if (bus_dataValid_i && (remain_r != 8'd0)) begin
               wrBeat_s    = 1'b1;
               nxtIdx_s    = idx_r + IDX_W'(1);
               nxtRemain_s = remain_r - 8'd1;
            end else begin
               wrBeat_s    = 1'b0;
            end
            if (bus_endTransaction_i) begin
               nxtState_s = IDLE;
            end else begin
               nxtState_s = WR_DATA;
            end
         end
         RD_WAIT: begin
            if (waitCnt_r == 4'd0) begin
               nxtState_s = RD_DATA;
            end else begin
               nxtWaitCnt_s = waitCnt_r - 4'd1;
            end
         end
         RD_DATA: begin
            rdBeat_s    = 1'b1;
            nxtValid_s  = 1'b1;
            nxtIdx_s    = idx_r + IDX_W'(1);
            nxtRemain_s = remain_r - 8'd1;
            if (remain_r == 8'd1) begin
               nxtEnd_s   = 1'b1;
               nxtState_s = IDLE;
            end else begin
               nxtState_s = RD_DATA;
            end
         end
         ERR: begin
            nxtErr_s   = 1'b1;
            nxtEnd_s   = 1'b1;
            nxtState_s = IDLE;
         end
         default: begin
            nxtState_s = IDLE;
         end
      endcase
      nxtBusy_s = rdBeat_s || (nxtState_s == RD_WAIT) || (nxtState_s == RD_DATA);
   end

   // State, capture registers and registered bus outputs (zero whenever not driving)
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r              <= IDLE;
         idx_r                <= '0;
         be_r                 <= 4'd0;
         remain_r             <= 8'd0;
         waitCnt_r            <= 4'd0;
         bus_addrData_o       <= 32'd0;
         bus_endTransaction_o <= 1'b0;
         bus_dataValid_o      <= 1'b0;
         bus_busy_o           <= 1'b0;
         bus_error_o          <= 1'b0;
      end else begin
         state_r              <= nxtState_s;
         idx_r                <= nxtIdx_s;
         be_r                 <= nxtBe_s;
         remain_r             <= nxtRemain_s;
         waitCnt_r            <= nxtWaitCnt_s;
         bus_addrData_o       <= rdBeat_s ? mem_r[idx_r] : 32'd0;
         bus_endTransaction_o <= nxtEnd_s;
         bus_dataValid_o      <= nxtValid_s;
         bus_busy_o           <= nxtBusy_s;
         bus_error_o          <= nxtErr_s;
      end
   end

   // RAM write port with per-byte lane enables; contents survive reset
   always_ff @(posedge clk) begin
      if (wrBeat_s && !rst) begin
         for (int b = 0; b < 4; b++) begin
            if (be_r[b]) begin
               mem_r[idx_r][8*b +: 8] <= bus_addrData_i[8*b +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_bus_ram_slave.sv
// Scoreboard bench for bus_ram_slave: randomized and directed traffic against an array model of the RAM.
module tb_bus_ram_slave;

   localparam logic [31:0] BASE = 32'h0001_0000;
   localparam int SIZE = 1024;
   localparam int RW   = 1;
`ifdef BUS_RAM_WRAP_BURST_EN
   localparam bit WRAP = 1'b1;
`else
   localparam bit WRAP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] addrData_i;
   logic [3:0]  byteEn_i;
   logic [7:0]  burst_i;
   logic        rnw_i, begin_i, end_i, valid_i;
   logic [31:0] addrData_o;
   logic        end_o, valid_o, busy_o, error_o;

   always #5 clk = ~clk;

   bus_ram_slave #(.BASE_ADDR(BASE), .SIZE_WORDS(SIZE), .READ_WAIT(RW)) dut (
      .clk(clk), .rst(rst),
      .bus_addrData_i(addrData_i), .bus_byteEnables_i(byteEn_i), .bus_burstSize_i(burst_i),
      .bus_readNWrite_i(rnw_i), .bus_beginTransaction_i(begin_i),
      .bus_endTransaction_i(end_i), .bus_dataValid_i(valid_i),
      .bus_addrData_o(addrData_o), .bus_endTransaction_o(end_o),
      .bus_dataValid_o(valid_o), .bus_busy_o(busy_o), .bus_error_o(error_o)
   );

   typedef struct {
      logic [31:0] data;
      logic        last;
      int          cyc;
   } beat_t;

   beat_t       expQ[$];
   beat_t       monBeat;
   logic [31:0] model [SIZE];
   int          nChecks = 0;
   int          nFails = 0;
   int          cyc = 0;
   int          errPending = 0;
   bit          rdActive = 1'b0;
   bit          monOn = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic bit isHit(input logic [31:0] a);
      logic [63:0] a64, lo, hi;
      a64 = {32'd0, a};
      lo  = {32'd0, BASE};
      hi  = lo + 64'(4 * SIZE);
      return (a64 >= lo) && (a64 < hi);
   endfunction

   // Response monitor: every presented beat or error is matched against the scoreboard.
   always @(negedge clk) begin
      if (monOn) begin
         if (valid_o === 1'b1) begin
            if (expQ.size() == 0) begin
               nChecks++;
               nFails++;
               $display("FAIL unexpected_beat: got data %h, no read pending", addrData_o);
            end else begin
               monBeat = expQ.pop_front();
               chk("rd_data", addrData_o, monBeat.data);
               chk("rd_end", 32'(end_o), 32'(monBeat.last));
               chk("rd_busy", 32'(busy_o), 32'd1);
               chk("rd_cycle", 32'(cyc), 32'(monBeat.cyc));
               chk("rd_noerr", 32'(error_o), 32'd0);
            end
         end else if (error_o === 1'b1) begin
            if (errPending > 0) begin
               chk("err_end", 32'(end_o), 32'd1);
               chk("err_busy", 32'(busy_o), 32'd0);
               errPending--;
            end else begin
               nChecks++;
               nFails++;
               $display("FAIL unexpected_error: got error 1 expected 0");
            end
         end else if (!rdActive) begin
            chk("idle_data", addrData_o, 32'd0);
            chk("idle_busy", 32'(busy_o), 32'd0);
            chk("idle_end", 32'(end_o), 32'd0);
         end
      end
   end

   task automatic waitDone();
      bit done;
      done = 1'b0;
      for (int t = 0; t < 400; t++) begin
         if (expQ.size() == 0 && errPending == 0) begin
            done = 1'b1;
            break;
         end
         @(negedge clk);
         #1;
      end
      if (!done) begin
         nChecks++;
         nFails++;
         $display("FAIL timeout: got %0d beats and %0d errors outstanding, expected 0", expQ.size(), errPending);
         expQ.delete();
         errPending = 0;
      end
      tick();
   endtask

   task automatic driveBegin(input logic [31:0] addr, input logic [3:0] be, input logic [7:0] bs, input logic rnw);
      addrData_i = addr;
      byteEn_i   = be;
      burst_i    = bs;
      rnw_i      = rnw;
      begin_i    = 1'b1;
   endtask

   task automatic idleBus();
      addrData_i = 32'd0;
      byteEn_i   = 4'd0;
      burst_i    = 8'd0;
      rnw_i      = 1'b0;
      begin_i    = 1'b0;
      end_i      = 1'b0;
      valid_i    = 1'b0;
   endtask

   task automatic wrTxn(input logic [31:0] addr, input logic [3:0] be, input logic [7:0] bs,
                        input int nBeats, input logic [31:0] d0, input bit fixed, input bit gaps);
      int n, wi, rem;
      bit hit, active;
      logic [31:0] d;
      n      = (bs == 8'd0) ? 1 : int'(bs);
      hit    = isHit(addr);
      wi     = hit ? int'((addr - BASE) >> 2) : 0;
      active = hit && (WRAP || (wi + n <= SIZE));
      if (hit && !active) errPending++;
      rem = n;
      driveBegin(addr, be, bs, 1'b0);
      tick();
      idleBus();
      for (int b = 0; b < nBeats; b++) begin
         if (gaps && $urandom_range(0, 2) == 0) begin
            valid_i    = 1'b0;
            addrData_i = $urandom;
            tick();
         end
         d          = fixed ? d0 + 32'(b) : 32'($urandom);
         addrData_i = d;
         valid_i    = 1'b1;
         end_i      = (b == nBeats - 1);
         if (active && rem > 0) begin
            for (int l = 0; l < 4; l++) begin
               if (be[l]) model[wi][8*l +: 8] = d[8*l +: 8];
            end
            wi = (wi + 1) % SIZE;
            rem--;
         end
         tick();
      end
      idleBus();
      waitDone();
   endtask

   task automatic rdTxn(input logic [31:0] addr, input logic [7:0] bs);
      int n, idx, k;
      bit hit;
      n   = (bs == 8'd0) ? 1 : int'(bs);
      hit = isHit(addr);
      idx = hit ? int'((addr - BASE) >> 2) : 0;
      k   = cyc;
      driveBegin(addr, 4'hF, bs, 1'b1);
      if (hit) begin
         if (!WRAP && (idx + n > SIZE)) begin
            errPending++;
         end else begin
            rdActive = 1'b1;
            for (int j = 0; j < n; j++) begin
               expQ.push_back('{data: model[(idx + j) % SIZE], last: (j == n - 1), cyc: k + RW + 2 + j});
            end
         end
      end
      tick();
      idleBus();
      if (rdActive) chk("busy_capture", 32'(busy_o), 32'd1);
      waitDone();
      rdActive = 1'b0;
   endtask

   initial begin
      int k, n, idx;
      idleBus();
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      chk("reset_data", addrData_o, 32'd0);
      chk("reset_valid", 32'(valid_o), 32'd0);
      chk("reset_busy", 32'(busy_o), 32'd0);
      chk("reset_end", 32'(end_o), 32'd0);
      chk("reset_error", 32'(error_o), 32'd0);
      monOn = 1'b1;

      for (int i = 0; i < 8; i++) wrTxn(BASE + 32'(512 * i), 4'hF, 8'd128, 128, 32'd0, 1'b0, 1'b0);

      wrTxn(BASE + 32'h10, 4'hF, 8'd1, 1, 32'hDEAD_BEEF, 1'b1, 1'b0);
      rdTxn(BASE + 32'h10, 8'd1);

      wrTxn(BASE + 32'h40, 4'hF, 8'd1, 1, 32'h1122_3344, 1'b1, 1'b0);
      wrTxn(BASE + 32'h40, 4'b0101, 8'd1, 1, 32'hAABB_CCDD, 1'b1, 1'b0);
      rdTxn(BASE + 32'h40, 8'd0);

      wrTxn(BASE + 32'h20, 4'hF, 8'd4, 4, 32'd1, 1'b1, 1'b1);
      rdTxn(BASE + 32'h20, 8'd4);

      wrTxn(BASE - 32'd4, 4'hF, 8'd1, 1, 32'hBAD0_BAD0, 1'b1, 1'b0);
      wrTxn(BASE + 32'(4 * SIZE), 4'hF, 8'd2, 2, 32'hBAD1_BAD1, 1'b1, 1'b0);
      rdTxn(BASE - 32'd4, 8'd1);
      rdTxn(BASE + 32'(4 * SIZE), 8'd4);
      repeat (4) tick();
      rdTxn(BASE, 8'd1);
      rdTxn(BASE + 32'(4 * (SIZE - 1)), 8'd1);

      rdTxn(BASE + 32'(4 * (SIZE - 1)), 8'd2);
      wrTxn(BASE + 32'(4 * (SIZE - 1)), 4'hF, 8'd2, 2, 32'h5A5A_0000, 1'b1, 1'b0);
      rdTxn(BASE, 8'd1);
      rdTxn(BASE + 32'(4 * (SIZE - 1)), 8'd1);

      // Reset in the cycle the second of four read beats is on the bus.
      k = cyc;
      driveBegin(BASE + 32'd400, 4'hF, 8'd4, 1'b1);
      rdActive = 1'b1;
      for (int j = 0; j < 2; j++) expQ.push_back('{data: model[100 + j], last: 1'b0, cyc: k + RW + 2 + j});
      tick();
      idleBus();
      repeat (RW + 2) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      rdActive = 1'b0;
      chk("rst_mid_valid", 32'(valid_o), 32'd0);
      chk("rst_mid_busy", 32'(busy_o), 32'd0);
      chk("rst_mid_data", addrData_o, 32'd0);
      chk("rst_mid_drain", 32'(expQ.size()), 32'd0);
      expQ.delete();
      rdTxn(BASE + 32'h10, 8'd1);
      rdTxn(BASE + 32'd400, 8'd3);

      for (int t = 0; t < 60; t++) begin
         n   = $urandom_range(0, 8);
         idx = $urandom_range(0, SIZE - 9);
         if ($urandom_range(0, 1) == 1) begin
            rdTxn(BASE + 32'(4 * idx) + 32'($urandom_range(0, 3)), 8'(n));
         end else begin
            wrTxn(BASE + 32'(4 * idx) + 32'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 8'(n),
                  ((n == 0) ? 1 : n) + $urandom_range(0, 2), 32'd0, 1'b0, 1'b1);
         end
      end

      chk("queue_drained", 32'(expQ.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
